prf_ram_mp: RTL

- Next-generation physical register file RAM for the issue/register-read stage.
- Generalises the fixed per-width port list into RPORT read and WPORT write ports on packed buses.
- Adds optional registered (synchronous) reads with write-first bypass and deterministic write-port priority.
- Replaces the single-cycle whole-array reset with a multi-cycle clear sequencer, so the array can map onto compiled SRAM.

---
 rtl/prf_ram_mp.sv | 114 +++++++++++
 1 files changed

// File: rtl/prf_ram_mp.sv
// Multi-ported physical register file RAM with a multi-cycle clear sequencer,
// optional registered reads with write-first bypass, and write-conflict detection.
module prf_ram_mp #(
    parameter int RPORT    = 8,
    parameter int WPORT    = 4,
    parameter int DEPTH    = 128,
    parameter int INDEX    = 7,
    parameter int WIDTH    = 64,
    parameter int READ_REG = 1,
    parameter int CLR_RATE = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [RPORT*INDEX-1:0] rd_addr_i,
    input  logic [RPORT-1:0]       rd_en_i,
    output logic [RPORT*WIDTH-1:0] rd_data_o,
    input  logic [WPORT*INDEX-1:0] wr_addr_i,
    input  logic [WPORT*WIDTH-1:0] wr_data_i,
    input  logic [WPORT-1:0]       wr_en_i,
    output logic                   init_busy_o,
    output logic                   wr_conflict_o
);
    localparam int PTR_W = $clog2(DEPTH + CLR_RATE + 1);

    typedef enum logic {INIT, READY} state_t;

    state_t                          state;
    logic [PTR_W-1:0]                ptr;
    logic [WIDTH-1:0]                ram [DEPTH];
    logic [RPORT-1:0][INDEX-1:0]     rd_addr;
    logic [WPORT-1:0][INDEX-1:0]     wr_addr;
    logic [WPORT-1:0][WIDTH-1:0]     wr_data;
    logic [RPORT-1:0][WIDTH-1:0]     ram_rd;
    logic [RPORT-1:0][WIDTH-1:0]     byp_rd;
    logic [WPORT-1:0]                wr_ok;
    logic                            conflict;

    assign rd_addr     = rd_addr_i;
    assign wr_addr     = wr_addr_i;
    assign wr_data     = wr_data_i;
    assign init_busy_o = (state == INIT);

    always_comb begin
        for (int w = 0; w < WPORT; w++)
            wr_ok[w] = wr_en_i[w] && (32'(wr_addr[w]) < DEPTH);
        conflict = 1'b0;
        for (int a = 0; a < WPORT; a++)
            for (int b = a + 1; b < WPORT; b++)
                if (wr_ok[a] && wr_ok[b] && wr_addr[a] == wr_addr[b])
                    conflict = 1'b1;
    end

    // Ascending port scan so the highest-numbered matching writer wins the bypass.
    always_comb begin
        for (int p = 0; p < RPORT; p++) begin
            ram_rd[p] = '0;
            if (32'(rd_addr[p]) < DEPTH)
                ram_rd[p] = ram[rd_addr[p]];
            byp_rd[p] = ram_rd[p];
            for (int w = 0; w < WPORT; w++)
                if (wr_ok[w] && wr_addr[w] == rd_addr[p])
                    byp_rd[p] = wr_data[w];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= INIT;
            ptr           <= '0;
            wr_conflict_o <= 1'b0;
        end else begin
            wr_conflict_o <= (state == READY) && conflict;
            if (state == INIT) begin
                ptr <= ptr + PTR_W'(CLR_RATE);
                if (32'(ptr) + CLR_RATE >= DEPTH)
                    state <= READY;
            end
        end
    end

    // Array storage carries no reset so it can map onto a compiled SRAM macro.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == INIT) begin
                for (int i = 0; i < CLR_RATE; i++)
                    if (32'(ptr) + i < DEPTH)
                        ram[INDEX'(32'(ptr) + i)] <= '0;
            end else begin
                for (int w = 0; w < WPORT; w++)
                    if (wr_ok[w])
                        ram[wr_addr[w]] <= wr_data[w];
            end
        end
    end

    generate
        if (READ_REG != 0) begin : g_reg
            logic [RPORT-1:0][WIDTH-1:0] rd_q;
            always_ff @(posedge clk) begin
                if (reset)
                    rd_q <= '0;
                else if (state == READY)
                    for (int p = 0; p < RPORT; p++)
                        if (rd_en_i[p])
                            rd_q[p] <= byp_rd[p];
            end
            assign rd_data_o = rd_q;
        end else begin : g_comb
            logic unused_rd;
            assign unused_rd = ^{rd_en_i, byp_rd};
            assign rd_data_o = init_busy_o ? '0 : ram_rd;
        end
    endgenerate
endmodule
